rv32i_regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port between NUM_REQ producers: writeback stage, load unit and CSR unit.
- Each producer offers {addr, data} on a valid/ready handshake.
- The arbiter grants one producer, drives the register-file write interface until the file acknowledges, then releases.
- Exports the in-flight destination register for the hazard/scoreboard logic in decode.

---
 rtl/rv32i_regfile_write_arbiter_pkg.sv | 23 ++
 rtl/rv32i_regfile_write_arbiter_rr_grant.sv | 45 ++++
 rtl/rv32i_regfile_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_rv32i_regfile_write_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Optional build macro used by the arbiter files: RV32I_REGFILE_ARB_FIXED_PRIO_EN.
package RV32I_core_utils_package;

    localparam int         REGFILE_WORD_SIZE = 32;
    localparam logic [4:0] REG_ZERO_ADDR     = 5'd0;

    typedef enum logic [0:0] {
        ArbIdle  = 1'b0,
        ArbWrite = 1'b1
    } regfile_arb_state_e;

    typedef struct packed {
        logic [4:0]                   addr;
        logic [REGFILE_WORD_SIZE-1:0] data;
    } regfile_write_req_t;

    // Index width that stays legal for a single-entry vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv32i_regfile_write_arbiter_rr_grant.sv
// Combinational one-hot picker: round-robin from ptr_i upward with wrap.
// With RV32I_REGFILE_ARB_FIXED_PRIO_EN defined it becomes a priority
// encoder (lowest index wins) and ptr_i is ignored.
module rv32i_rr_grant #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int k;

    // Pick the first valid requester in search order and mark it one-hot.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        k       = 0;
`ifdef RV32I_REGFILE_ARB_FIXED_PRIO_EN
        for (int off = 0; off < NUM_REQ; off++) begin
            k = off;
            if (!any_o && valid_i[k]) begin
                any_o      = 1'b1;
                idx_o      = IDX_W'(k);
                grant_o[k] = 1'b1;
            end
        end
`else
        for (int off = 0; off < NUM_REQ; off++) begin
            k = (int'(ptr_i) + off) % NUM_REQ;
            if (!any_o && valid_i[k]) begin
                any_o      = 1'b1;
                idx_o      = IDX_W'(k);
                grant_o[k] = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/rv32i_regfile_write_arbiter.sv
// Arbitrates NUM_REQ producers onto the single register-file write port,
// holds the write until acknowledged (or timed out) and exports the
// in-flight destination for decode hazard logic.
// Build option: RV32I_REGFILE_ARB_FIXED_PRIO_EN selects fixed priority
// (index 0 first) instead of round-robin.
module rv32i_regfile_write_arbiter
    import RV32I_core_utils_package::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [NUM_REQ*5-1:0]   i_req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0] i_req_data,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_register_write_en,
    output logic [4:0]             o_register_write_addr,
    output logic [WORD_SIZE-1:0]   o_register_write_data,
    input  logic                   i_register_write_valid,
    output logic                   o_pending_valid,
    output logic [4:0]             o_pending_addr,
    output logic                   o_error
);

    localparam int IDX_W = clog2_min1(NUM_REQ);
    localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES);

    regfile_arb_state_e     state_q, state_d;
    logic                   we_q, we_d;
    logic [4:0]             waddr_q, waddr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic                   pend_q, pend_d;
    logic [4:0]             pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;

    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [4:0]             sel_addr;
    logic [WORD_SIZE-1:0]   sel_data;

    rv32i_rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_grant (
        .valid_i (i_req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // Mux the granted requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant[r]) begin
                sel_addr = i_req_addr[r*5 +: 5];
                sel_data = i_req_data[r*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Next-state and ready logic for the Idle/Write handshake FSM.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        ptr_d       = ptr_q;
        o_req_ready = '0;
        case (state_q)
            ArbIdle: begin
                o_req_ready = grant;
                if (grant_any) begin
                    // Pointer moves on every accepted transfer, including x0 discards.
                    ptr_d = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
                    if (sel_addr != REG_ZERO_ADDR) begin
                        we_d        = 1'b1;
                        waddr_d     = sel_addr;
                        wdata_d     = sel_data;
                        pend_d      = 1'b1;
                        pend_addr_d = sel_addr;
                        cnt_d       = '0;
                        state_d     = ArbWrite;
                    end
                end
            end
            ArbWrite: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack wins over a coincident timeout.
                if (i_register_write_valid) begin
                    we_d    = 1'b0;
                    pend_d  = 1'b0;
                    state_d = ArbIdle;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
                    err_d   = 1'b1;
                    we_d    = 1'b0;
                    pend_d  = 1'b0;
                    state_d = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase
`ifdef RV32I_REGFILE_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`endif
    end

    // State and write-port registers; reset abandons any in-flight write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ArbIdle;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            ptr_q       <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q     <= state_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign o_register_write_en   = we_q;
    assign o_register_write_addr = waddr_q;
    assign o_register_write_data = wdata_q;
    assign o_pending_valid       = pend_q;
    assign o_pending_addr        = pend_addr_q;
    assign o_error               = err_q;

endmodule

// File: tb/tb_rv32i_regfile_write_arbiter.sv
// Directed bench for rv32i_regfile_write_arbiter (follows
// RV32I_REGFILE_ARB_FIXED_PRIO_EN for the arbitration-order scenario).
module tb_rv32i_regfile_write_arbiter;

    localparam int W = 32;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   valid;
    logic [N*5-1:0] addr;
    logic [N*W-1:0] data;
    logic [N-1:0]   ready;
    logic           we;
    logic [4:0]     waddr;
    logic [W-1:0]   wdata;
    logic           ack;
    logic           pv;
    logic [4:0]     paddr;
    logic           err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    rv32i_regfile_write_arbiter #(
        .WORD_SIZE      (W),
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_req_valid            (valid),
        .i_req_addr             (addr),
        .i_req_data             (data),
        .o_req_ready            (ready),
        .o_register_write_en    (we),
        .o_register_write_addr  (waddr),
        .o_register_write_data  (wdata),
        .i_register_write_valid (ack),
        .o_pending_valid        (pv),
        .o_pending_addr         (paddr),
        .o_error                (err)
    );

    task automatic set_req(input int k, input logic [4:0] a, input logic [W-1:0] d);
        addr[k*5 +: 5] = a;
        data[k*W +: W] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0;
        addr  = '0;
        data  = '0;
        ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = '0;
        addr  = '0;
        data  = '0;
        ack   = 1'b0;
        @(negedge clk);
        #1;
        total_cnt++; if (we !== 1'b0) $display("FAIL reset_we: got %b want 0", we); else pass_cnt++;
        total_cnt++; if (pv !== 1'b0) $display("FAIL reset_pending: got %b want 0", pv); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_error: got %b want 0", err); else pass_cnt++;
        total_cnt++; if (waddr !== 5'd0 || paddr !== 5'd0) $display("FAIL reset_addr: got %0d/%0d want 0/0", waddr, paddr); else pass_cnt++;
        total_cnt++; if (wdata !== 32'd0) $display("FAIL reset_data: got %h want 0", wdata); else pass_cnt++;
        total_cnt++; if (ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int pulses;
        do_reset();
        pulses = 0;
        set_req(0, 5'd5, 32'hDEADBEEF);
        valid = 3'b001;
        #1;
        total_cnt++; if (ready !== 3'b001) $display("FAIL single_ready: got %b want 001", ready); else pass_cnt++;
        if (ready[0] === 1'b1) pulses++;
        @(negedge clk);
        valid = '0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            if (ready[0] === 1'b1) pulses++;
            total_cnt++; if (we !== 1'b1) $display("FAIL single_we_c%0d: got %b want 1", c, we); else pass_cnt++;
            total_cnt++; if (ready !== 3'b000) $display("FAIL single_ready_busy_c%0d: got %b want 000", c, ready); else pass_cnt++;
            if (c == 1) begin
                total_cnt++; if (waddr !== 5'd5) $display("FAIL single_waddr: got %0d want 5", waddr); else pass_cnt++;
                total_cnt++; if (wdata !== 32'hDEADBEEF) $display("FAIL single_wdata: got %h want deadbeef", wdata); else pass_cnt++;
                total_cnt++; if (pv !== 1'b1 || paddr !== 5'd5) $display("FAIL single_pending: got %b/%0d want 1/5", pv, paddr); else pass_cnt++;
            end
            if (c == 3) ack = 1'b1;
            @(negedge clk);
        end
        #1;
        ack = 1'b0;
        total_cnt++; if (we !== 1'b0 || pv !== 1'b0) $display("FAIL single_release: got we=%b pv=%b want 0/0", we, pv); else pass_cnt++;
        total_cnt++; if (pulses != 1) $display("FAIL single_ready_pulses: got %0d want 1", pulses); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic run_grants(input string tag, input int e0, input int e1, input int e2, input int e3, input int rounds);
        int exp_idx [4];
        logic [N-1:0] exp_ready;
        exp_idx = '{e0, e1, e2, e3};
        for (int i = 0; i < rounds; i++) begin
            exp_ready = '0;
            exp_ready[exp_idx[i]] = 1'b1;
            #1;
            total_cnt++; if (ready !== exp_ready) $display("FAIL %s_ready_%0d: got %b want %b", tag, i, ready, exp_ready); else pass_cnt++;
            @(negedge clk);
            #1;
            total_cnt++; if (we !== 1'b1 || waddr !== addr[exp_idx[i]*5 +: 5])
                $display("FAIL %s_write_%0d: got we=%b addr=%0d want 1/%0d", tag, i, we, waddr, addr[exp_idx[i]*5 +: 5]);
            else pass_cnt++;
            total_cnt++; if (ready !== 3'b000) $display("FAIL %s_busy_%0d: got %b want 000", tag, i, ready); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_contention();
        do_reset();
        set_req(0, 5'd1, 32'h1111_1111);
        set_req(1, 5'd2, 32'h2222_2222);
        set_req(2, 5'd3, 32'h3333_3333);
        valid = 3'b111;
        ack   = 1'b1;
        run_grants("contention", 0, 1, 2, 0, 4);
        valid = '0;
        ack   = 1'b0;
        #1;
        total_cnt++; if (we !== 1'b0) $display("FAIL contention_end_we: got %b want 0", we); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_x0_discard();
        do_reset();
        set_req(1, 5'd0, 32'hCAFE_F00D);
        valid = 3'b010;
        #1;
        total_cnt++; if (ready !== 3'b010) $display("FAIL x0_ready: got %b want 010", ready); else pass_cnt++;
        @(negedge clk);
        valid = '0;
        #1;
        total_cnt++; if (we !== 1'b0 || pv !== 1'b0) $display("FAIL x0_no_write: got we=%b pv=%b want 0/0", we, pv); else pass_cnt++;
        set_req(0, 5'd4, 32'h4);
        set_req(1, 5'd6, 32'h6);
        set_req(2, 5'd8, 32'h8);
        valid = 3'b111;
        #1;
        total_cnt++; if (ready !== 3'b100) $display("FAIL x0_ptr_adv: got %b want 100", ready); else pass_cnt++;
        @(negedge clk);
        valid = '0;
        #1;
        total_cnt++; if (we !== 1'b1 || waddr !== 5'd8) $display("FAIL x0_next_write: got we=%b addr=%0d want 1/8", we, waddr); else pass_cnt++;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        set_req(0, 5'd0, 32'h0);
        set_req(1, 5'd0, 32'h0);
        set_req(2, 5'd0, 32'h0);
        valid = 3'b111;
        #1;
        total_cnt++; if (ready !== 3'b001) $display("FAIL x0_b2b_0: got %b want 001", ready); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (ready !== 3'b010 || we !== 1'b0) $display("FAIL x0_b2b_1: got ready=%b we=%b want 010/0", ready, we); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (ready !== 3'b100 || we !== 1'b0) $display("FAIL x0_b2b_2: got ready=%b we=%b want 100/0", ready, we); else pass_cnt++;
        @(negedge clk);
        valid = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        do_reset();
        set_req(0, 5'd7, 32'h0000_1234);
        valid = 3'b001;
        @(negedge clk);
        valid = '0;
        cyc = 0;
        #1;
        while (we === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        total_cnt++; if (cyc != 16) $display("FAIL timeout_len: got %0d cycles want 16", cyc); else pass_cnt++;
        total_cnt++; if (err !== 1'b1 || pv !== 1'b0) $display("FAIL timeout_err: got err=%b pv=%b want 1/0", err, pv); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        #1;
        total_cnt++; if (err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", err); else pass_cnt++;
        set_req(1, 5'd9, 32'h0000_0009);
        valid = 3'b010;
        #1;
        total_cnt++; if (ready !== 3'b010) $display("FAIL timeout_next_ready: got %b want 010", ready); else pass_cnt++;
        @(negedge clk);
        valid = '0;
        #1;
        total_cnt++; if (we !== 1'b1 || waddr !== 5'd9) $display("FAIL timeout_next_write: got we=%b addr=%0d want 1/9", we, waddr); else pass_cnt++;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        #1;
        total_cnt++; if (we !== 1'b0 || err !== 1'b1) $display("FAIL timeout_next_done: got we=%b err=%b want 0/1", we, err); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        set_req(2, 5'd12, 32'h0000_000C);
        valid = 3'b100;
        #1;
        total_cnt++; if (ready !== 3'b100) $display("FAIL midrst_ready: got %b want 100", ready); else pass_cnt++;
        @(negedge clk);
        valid = '0;
        #1;
        total_cnt++; if (we !== 1'b1 || err !== 1'b1) $display("FAIL midrst_pre: got we=%b err=%b want 1/1", we, err); else pass_cnt++;
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (we !== 1'b0 || pv !== 1'b0 || err !== 1'b0 || paddr !== 5'd0)
            $display("FAIL midrst_async: got we=%b pv=%b err=%b paddr=%0d want 0/0/0/0", we, pv, err, paddr);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_req(0, 5'd3, 32'h3);
        valid = 3'b001;
        #1;
        total_cnt++; if (ready !== 3'b001) $display("FAIL midrst_idle: got %b want 001", ready); else pass_cnt++;
        @(negedge clk);
        valid = '0;
        ack   = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout_ack_same_cycle();
        do_reset();
        set_req(0, 5'd15, 32'h0000_00FF);
        valid = 3'b001;
        @(negedge clk);
        valid = '0;
        for (int c = 1; c <= 16; c++) begin
            #1;
            if (c == 16) begin
                total_cnt++; if (we !== 1'b1) $display("FAIL tack_last_cycle: got %b want 1", we); else pass_cnt++;
                ack = 1'b1;
            end
            @(negedge clk);
        end
        #1;
        ack = 1'b0;
        total_cnt++; if (we !== 1'b0 || err !== 1'b0) $display("FAIL tack_no_err: got we=%b err=%b want 0/0", we, err); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_priority();
        do_reset();
        set_req(0, 5'd10, 32'h0000_000A);
        set_req(2, 5'd20, 32'h0000_0014);
        valid = 3'b101;
        ack   = 1'b1;
`ifdef RV32I_REGFILE_ARB_FIXED_PRIO_EN
        run_grants("prio", 0, 0, 0, 0, 3);
`else
        run_grants("prio", 0, 2, 0, 0, 3);
`endif
        valid = 3'b100;
        #1;
        total_cnt++; if (ready !== 3'b100) $display("FAIL prio_req2_alone: got %b want 100", ready); else pass_cnt++;
        @(negedge clk);
        valid = '0;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_x0_discard();
        test_timeout();
        test_reset_mid_write();
        test_timeout_ack_same_cycle();
        test_priority();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
